// File: rtl/bp_common_aviary_pkg.sv
// Processor configuration parameters: field enumeration, parameter struct and
// the table of named configurations served by the configuration reader.
package bp_common_aviary_pkg;

  localparam int bp_cfg_num_fields_gp = 41;

  typedef enum logic [1:0] {
    e_bp_single_core_cfg = 2'd0,
    e_bp_dual_core_cfg   = 2'd1
  } bp_cfg_e;

  localparam int bp_num_cfgs_gp = 2;

  typedef enum logic [5:0] {
    e_cc_x_dim, e_cc_y_dim, e_ic_y_dim, e_mc_y_dim, e_cac_x_dim, e_sac_x_dim,
    e_paddr_width, e_vaddr_width, e_asid_width, e_branch_metadata_fwd_width,
    e_btb_tag_width, e_btb_idx_width, e_bht_idx_width, e_ras_idx_width,
    e_itlb_els, e_dtlb_els, e_lce_sets, e_lce_assoc, e_cce_pc_width,
    e_cce_block_width, e_ucode, e_l2_en, e_l2_sets, e_l2_assoc,
    e_l2_outstanding_reqs, e_fe_queue_fifo_els, e_fe_cmd_fifo_els,
    e_async_coh_clk, e_coh_noc_max_credits, e_coh_noc_flit_width,
    e_coh_noc_cid_width, e_coh_noc_len_width, e_async_mem_clk,
    e_mem_noc_max_credits, e_mem_noc_flit_width, e_mem_noc_cid_width,
    e_mem_noc_len_width, e_async_io_clk, e_io_noc_max_credits,
    e_io_noc_flit_width, e_io_noc_len_width
  } bp_cfg_field_e;

  // Member order must match bp_cfg_field_e; the field mux relies on it.
  typedef struct packed {
    logic [31:0] cc_x_dim, cc_y_dim, ic_y_dim, mc_y_dim, cac_x_dim, sac_x_dim;
    logic [31:0] paddr_width, vaddr_width, asid_width, branch_metadata_fwd_width;
    logic [31:0] btb_tag_width, btb_idx_width, bht_idx_width, ras_idx_width;
    logic [31:0] itlb_els, dtlb_els, lce_sets, lce_assoc, cce_pc_width;
    logic [31:0] cce_block_width, ucode, l2_en, l2_sets, l2_assoc;
    logic [31:0] l2_outstanding_reqs, fe_queue_fifo_els, fe_cmd_fifo_els;
    logic [31:0] async_coh_clk, coh_noc_max_credits, coh_noc_flit_width;
    logic [31:0] coh_noc_cid_width, coh_noc_len_width, async_mem_clk;
    logic [31:0] mem_noc_max_credits, mem_noc_flit_width, mem_noc_cid_width;
    logic [31:0] mem_noc_len_width, async_io_clk, io_noc_max_credits;
    logic [31:0] io_noc_flit_width, io_noc_len_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_single_core_cfg_p = '{
    1, 1, 1, 0, 0, 0, 40, 39, 1, 37, 9, 6, 7, 2, 8, 8, 64, 8, 8, 512, 0,
    1, 128, 8, 8, 8, 4, 0, 8, 128, 1, 3, 0, 8, 64, 2, 4, 0, 16, 64, 4
  };

  localparam bp_proc_param_s bp_dual_core_cfg_p = '{
    2, 1, 1, 0, 0, 0, 40, 39, 1, 37, 9, 6, 7, 2, 8, 8, 64, 8, 8, 512, 0,
    1, 128, 8, 8, 8, 4, 0, 8, 128, 2, 3, 0, 8, 64, 2, 4, 0, 16, 64, 4
  };

  localparam bp_proc_param_s all_cfgs_gp [bp_num_cfgs_gp] = '{
    bp_single_core_cfg_p,
    bp_dual_core_cfg_p
  };

endpackage

// File: rtl/bp_cfg_field_mux.sv
// Combinational selector returning one 32-bit field of a parameter struct,
// flagging indices beyond the last defined field.
module bp_cfg_field_mux
  import bp_common_aviary_pkg::*;
(
  input  bp_proc_param_s params_i,
  input  bp_cfg_field_e  field_i,
  output logic [31:0]    data_o,
  output logic           err_o
);

  localparam logic [5:0] num_fields_lp = 6'(bp_cfg_num_fields_gp);

  // Ascending word order puts the first declared member at index 0.
  logic [0:bp_cfg_num_fields_gp-1][31:0] words;
  assign words = params_i;

  always_comb begin
    data_o = '0;
    err_o  = 1'b1;
    if (6'(field_i) < num_fields_lp) begin
      data_o = words[6'(field_i)];
      err_o  = 1'b0;
    end
  end

endmodule

// File: rtl/bp_cfg_param_reader.sv
// Serves configuration fields of all_cfgs_gp[cfg_p] either one at a time or
// as a back-to-back stream of every field, through a held response register.
module bp_cfg_param_reader
  import bp_common_aviary_pkg::*;
#(
  parameter bp_cfg_e cfg_p        = e_bp_single_core_cfg,
  parameter int      data_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    req_v_i,
  output logic                    req_ready_o,
  input  logic                    req_dump_i,
  input  logic [5:0]              req_field_i,
  output logic                    resp_v_o,
  input  logic                    resp_yumi_i,
  output logic [data_width_p-1:0] resp_data_o,
  output logic [5:0]              resp_field_o,
  output logic                    resp_err_o,
  output logic                    resp_last_o
);

  localparam logic [1:0] e_idle   = 2'd0;
  localparam logic [1:0] e_single = 2'd1;
  localparam logic [1:0] e_dump   = 2'd2;

  localparam bp_proc_param_s params_lp     = all_cfgs_gp[cfg_p];
  localparam logic [5:0]     last_field_lp = 6'(bp_cfg_num_fields_gp - 1);

  logic [1:0]              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    resp_v_q, resp_v_d;
  logic [data_width_p-1:0] resp_data_q, resp_data_d;
  logic [5:0]              resp_field_q, resp_field_d;
  logic                    resp_err_q, resp_err_d;
  logic                    resp_last_q, resp_last_d;

  logic [5:0]  cnt_inc;
  logic [5:0]  mux_field;
  logic [31:0] mux_data;
  logic        mux_err;

  assign cnt_inc = cnt_q + 6'd1;
  // Idle looks up the incoming request; dump looks ahead to the next index.
  assign mux_field = (state_q == e_idle) ? (req_dump_i ? 6'd0 : req_field_i) : cnt_inc;

  bp_cfg_field_mux u_field_mux (
    .params_i (params_lp),
    .field_i  (bp_cfg_field_e'(mux_field)),
    .data_o   (mux_data),
    .err_o    (mux_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_v_d     = resp_v_q;
    resp_data_d  = resp_data_q;
    resp_field_d = resp_field_q;
    resp_err_d   = resp_err_q;
    resp_last_d  = resp_last_q;
    case (state_q)
      e_idle: begin
        if (req_v_i && ready_q) begin
          resp_v_d     = 1'b1;
          resp_data_d  = data_width_p'(mux_data);
          resp_field_d = mux_field;
          resp_err_d   = mux_err;
          if (req_dump_i) begin
            state_d     = e_dump;
            cnt_d       = 6'd0;
            resp_last_d = 1'b0;
          end else begin
            state_d     = e_single;
            resp_last_d = 1'b1;
          end
        end
      end
      e_single: begin
        if (resp_yumi_i) begin
          state_d  = e_idle;
          resp_v_d = 1'b0;
        end
      end
      e_dump: begin
        if (resp_yumi_i) begin
          if (cnt_q == last_field_lp) begin
            state_d  = e_idle;
            resp_v_d = 1'b0;
          end else begin
            cnt_d        = cnt_inc;
            resp_data_d  = data_width_p'(mux_data);
            resp_field_d = cnt_inc;
            resp_err_d   = mux_err;
            resp_last_d  = (cnt_inc == last_field_lp);
          end
        end
      end
      default: begin
        state_d  = e_idle;
        resp_v_d = 1'b0;
      end
    endcase
  end

  // Ready is registered so it stays low through reset and rises on the first edge after.
  assign ready_d = (state_d == e_idle);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_idle;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_v_q     <= 1'b0;
      resp_data_q  <= '0;
      resp_field_q <= '0;
      resp_err_q   <= 1'b0;
      resp_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      resp_v_q     <= resp_v_d;
      resp_data_q  <= resp_data_d;
      resp_field_q <= resp_field_d;
      resp_err_q   <= resp_err_d;
      resp_last_q  <= resp_last_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_v_o     = resp_v_q;
  assign resp_data_o  = resp_data_q;
  assign resp_field_o = resp_field_q;
  assign resp_err_o   = resp_err_q;
  assign resp_last_o  = resp_last_q;

endmodule
